// File: rtl/pwm_fade_if.sv
// Handshake and duty bundle between the fade sequencer, its delay counter
// and the PWM generator.
interface pwm_fade_if #(
    parameter int DUTY_W = 8
);
    logic              en_i;
    logic              done_i;
    logic              start_o;
    logic [DUTY_W-1:0] duty_o;
    logic              dir_o;
    logic              busy_o;
    logic              timeout_o;

    modport master (
        input  en_i,
        input  done_i,
        output start_o,
        output duty_o,
        output dir_o,
        output busy_o,
        output timeout_o
    );

    modport slave (
        output en_i,
        output done_i,
        input  start_o,
        input  duty_o,
        input  dir_o,
        input  busy_o,
        input  timeout_o
    );
endinterface

// File: rtl/pwm_fade_sequencer.sv
// Triangular duty ramp stepped by a start/done delay handshake.
// Optional WAIT_DONE watchdog enabled by defining FADE_TIMEOUT_EN.
module pwm_fade_sequencer #(
    parameter int DUTY_W         = 8,
    parameter int STEP           = 1,
    parameter int MAX_DUTY       = 255,
    parameter int TIMEOUT_CYCLES = 32767
) (
    input logic         clk,
    input logic         rst_i,
    pwm_fade_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2,
        UPDATE    = 2'd3
    } state_t;

    localparam logic [DUTY_W:0] STEP_X = (DUTY_W+1)'(STEP);
    localparam logic [DUTY_W:0] MAX_X  = (DUTY_W+1)'(MAX_DUTY);

    state_t            state_q;
    state_t            state_d;
    logic [DUTY_W-1:0] duty_q;
    logic [DUTY_W-1:0] duty_d;
    logic              dir_q;
    logic              dir_d;
    logic [DUTY_W:0]   up_sum;
    logic              wd_expire;

    // one bit of headroom so the ceiling compare never sees a wrapped sum
    assign up_sum = {1'b0, duty_q} + STEP_X;

`ifdef FADE_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wdog_q;
    logic            tmo_q;

    assign wd_expire = (state_q == WAIT_DONE) && (wdog_q == WD_LAST);

    always_ff @(posedge clk) begin
        if (rst_i || state_q != WAIT_DONE) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            tmo_q <= 1'b0;
        end else if (state_d == ISSUE && state_q != ISSUE) begin
            tmo_q <= 1'b0;
        end else if (wd_expire && !bus.done_i) begin
            tmo_q <= 1'b1;
        end
    end

    assign bus.timeout_o = tmo_q;
`else
    assign wd_expire     = 1'b0;
    assign bus.timeout_o = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        dir_d   = dir_q;
        unique case (state_q)
            IDLE: begin
                if (bus.en_i) state_d = ISSUE;
            end
            ISSUE: begin
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (bus.done_i) begin
                    state_d = UPDATE;
                end else if (wd_expire) begin
                    state_d = IDLE;
                end
            end
            UPDATE: begin
                state_d = bus.en_i ? ISSUE : IDLE;
                if (dir_q) begin
                    if (up_sum >= MAX_X) begin
                        duty_d = MAX_X[DUTY_W-1:0];
                        dir_d  = 1'b0;
                    end else begin
                        duty_d = up_sum[DUTY_W-1:0];
                    end
                end else begin
                    if ({1'b0, duty_q} <= STEP_X) begin
                        duty_d = '0;
                        dir_d  = 1'b1;
                    end else begin
                        duty_d = duty_q - STEP_X[DUTY_W-1:0];
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q <= IDLE;
            duty_q  <= '0;
            dir_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            dir_q   <= dir_d;
        end
    end

    assign bus.start_o = (state_q == ISSUE);
    assign bus.busy_o  = (state_q != IDLE);
    assign bus.duty_o  = duty_q;
    assign bus.dir_o   = dir_q;

endmodule

// File: tb/tb_pwm_fade_sequencer.sv
// Scoreboard bench for pwm_fade_sequencer with a 5-cycle delay counter model.
// Each expected {dir,duty} is queued by stimulus and checked on every start_o.
module tb_pwm_fade_sequencer;

    logic clk = 1'b0;
    logic rst_i;
    logic mdl_done = 1'b0;
    logic spur_done = 1'b0;
    bit   model_on = 1'b1;
    bit   prev_start = 1'b0;
    int   dcnt = 0;
    int   checks = 0;
    int   errors = 0;
    logic [8:0] exp_q[$];

    always #5 clk = ~clk;

    pwm_fade_if #(.DUTY_W(8)) sif ();

    assign sif.done_i = mdl_done | spur_done;

    pwm_fade_sequencer #(
        .DUTY_W(8),
        .STEP(100),
        .MAX_DUTY(255),
        .TIMEOUT_CYCLES(16)
    ) u_dut (
        .clk(clk),
        .rst_i(rst_i),
        .bus(sif)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // delay counter model: done_i pulse 5 cycles after start_o is seen
    always @(negedge clk) begin
        if (dcnt > 0) begin
            dcnt--;
            mdl_done = (dcnt == 0);
        end else begin
            mdl_done = 1'b0;
        end
        if (model_on && sif.start_o) dcnt = 5;
    end

    // monitor: every start_o pulse pops the expected {dir,duty}
    always @(negedge clk) begin
        if (sif.start_o) begin
            check("start_width", int'(prev_start), 0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_start actual=%0d required=none",
                         sif.duty_o);
            end else begin
                check("start_dir_duty", int'({sif.dir_o, sif.duty_o}),
                      int'(exp_q.pop_front()));
            end
        end
        prev_start = sif.start_o;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_drain(input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            tick();
            if (exp_q.size() == 0) return;
        end
        checks++;
        errors++;
        $display("FAIL wait_drain actual=%0d required=0", exp_q.size());
    endtask

    task automatic wait_idle(input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            tick();
            if (!sif.busy_o) return;
        end
        checks++;
        errors++;
        $display("FAIL wait_idle actual=1 required=0");
    endtask

    task automatic wait_done_seen(input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            tick();
            if (sif.done_i) return;
        end
        checks++;
        errors++;
        $display("FAIL wait_done actual=0 required=1");
    endtask

    task automatic push(input logic dir, input logic [7:0] duty);
        exp_q.push_back({dir, duty});
    endtask

    initial begin
        rst_i = 1'b1;
        sif.en_i = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_i = 1'b0;
        check("rst_duty", sif.duty_o, 0);
        check("rst_dir", sif.dir_o, 1);
        check("rst_busy", sif.busy_o, 0);
        check("rst_start", sif.start_o, 0);
        check("rst_timeout", sif.timeout_o, 0);

        // full sweep with clamped ends
        push(1, 0);   push(1, 100); push(1, 200); push(0, 255);
        push(0, 155); push(0, 55);  push(1, 0);   push(1, 100);
        sif.en_i = 1'b1;
        tick();
        check("first_start", sif.start_o, 1);
        check("first_busy", sif.busy_o, 1);
        wait_done_seen(50);
        check("lat_update_duty", sif.duty_o, 0);
        check("lat_update_busy", sif.busy_o, 1);
        tick();
        check("lat_new_duty", sif.duty_o, 100);
        check("lat_start", sif.start_o, 1);
        wait_drain(200);

        // stop in WAIT_DONE: handshake completes, one update, then idle
        sif.en_i = 1'b0;
        wait_idle(50);
        check("stop_duty", sif.duty_o, 200);
        check("stop_dir", sif.dir_o, 1);
        repeat (10) tick();
        check("stop_start", sif.start_o, 0);

        // restart resumes from held duty/dir
        push(1, 200); push(0, 255);
        sif.en_i = 1'b1;
        wait_drain(100);
        sif.en_i = 1'b0;
        wait_idle(50);
        check("resume_duty", sif.duty_o, 155);
        check("resume_dir", sif.dir_o, 0);

        // spurious done in IDLE
        spur_done = 1'b1;
        tick();
        spur_done = 1'b0;
        tick();
        check("spur_idle_duty", sif.duty_o, 155);
        check("spur_idle_busy", sif.busy_o, 0);

        // spurious done in the ISSUE cycle
        push(0, 155);
        sif.en_i = 1'b1;
        tick();
        check("spur_issue_start", sif.start_o, 1);
        spur_done = 1'b1;
        tick();
        spur_done = 1'b0;
        check("spur_issue_busy", sif.busy_o, 1);
        check("spur_issue_duty", sif.duty_o, 155);
        sif.en_i = 1'b0;
        wait_idle(50);
        check("spur_after_duty", sif.duty_o, 55);
        check("spur_after_dir", sif.dir_o, 0);

        // reset during WAIT_DONE; late done_i ignored
        push(0, 55);
        sif.en_i = 1'b1;
        wait_drain(50);
        sif.en_i = 1'b0;
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("midrst_duty", sif.duty_o, 0);
        check("midrst_dir", sif.dir_o, 1);
        check("midrst_busy", sif.busy_o, 0);
        repeat (10) tick();
        check("late_done_duty", sif.duty_o, 0);
        check("late_done_busy", sif.busy_o, 0);

        // delay counter never answers
        model_on = 1'b0;
        push(1, 0);
        sif.en_i = 1'b1;
        wait_drain(50);
        sif.en_i = 1'b0;
        repeat (15) tick();
        check("wd_pre_busy", sif.busy_o, 1);
        check("wd_pre_timeout", sif.timeout_o, 0);
        tick();
`ifdef FADE_TIMEOUT_EN
        check("wd_busy", sif.busy_o, 0);
        check("wd_timeout", sif.timeout_o, 1);
        check("wd_duty", sif.duty_o, 0);
        check("wd_dir", sif.dir_o, 1);
        push(1, 0);
        sif.en_i = 1'b1;
        tick();
        sif.en_i = 1'b0;
        check("wd_clr_start", sif.start_o, 1);
        check("wd_clr_timeout", sif.timeout_o, 0);
        repeat (20) tick();
        check("wd_again_timeout", sif.timeout_o, 1);
        check("wd_again_busy", sif.busy_o, 0);
`else
        check("nowd_busy", sif.busy_o, 1);
        check("nowd_timeout", sif.timeout_o, 0);
        sif.en_i = 1'b1;
        repeat (20) tick();
        check("nowd_hold_busy", sif.busy_o, 1);
        check("nowd_hold_timeout", sif.timeout_o, 0);
        sif.en_i = 1'b0;
`endif
        repeat (3) tick();
        check("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
